main_slave_port_master: RTL
===========================

# main_slave_port_master

Bus master for the slave memory port of a Bambu-generated `main` accelerator. It runs under a host/bench controller and handles the accelerator's run-control handshake:

- drives `S_oe_ram`, `S_we_ram`, `S_addr_ram`, `S_Wdata_ram` and `S_data_ram_size`;
- collects `Sout_Rdata_ram` and `Sout_DataRdy`;
- pulses `start_port` and counts cycles until `done_port`.

It preloads inputs, reads back results and measures latency in hardware.

## Interface
Parameters:
- ADDR_W, 7, address bits per channel
- DATA_W, 8, data bits per channel
- SIZE_W, 4, access-size field bits per channel
- TIMEOUT, 64, cycles to wait for DataRdy before reporting an error
- CNT_W, 32, run cycle counter width

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; all state and outputs forced to reset values while 0
- cmd_valid  in  1  memory command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_size  in  SIZE_W  access size in bits, passed to the port unchanged
- rsp_valid  out  1  response available, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes or on timeout)
- rsp_error  out  1  DataRdy timeout
- run_req  in  1  request one accelerator run
- run_busy  out  1  run in progress
- run_done  out  1  one-cycle pulse when done_port is seen
- run_cycles  out  CNT_W  latched cycle count of the last run
- start_port  out  1  accelerator start
- done_port  in  1  accelerator done
- S_oe_ram  out  2  read enable, lane 0 used, lane 1 tied 0
- S_we_ram  out  2  write enable, lane 0 used, lane 1 tied 0
- S_addr_ram  out  2*ADDR_W  lane 0 in [ADDR_W-1:0], rest 0
- S_Wdata_ram  out  2*DATA_W  lane 0 in [DATA_W-1:0], rest 0
- S_data_ram_size  out  2*SIZE_W  lane 0 in [SIZE_W-1:0], rest 0
- Sout_Rdata_ram  in  2*DATA_W  read data, lane 0 sampled
- Sout_DataRdy  in  2  access complete, bit 0 sampled

## Operation
- States: IDLE, ACCESS, WAIT, RESP, RUN.
- IDLE:
  - cmd_ready = 1 iff run_req = 0. run_req has priority over cmd_valid in the same cycle.
  - On run_req: go to RUN, pulse start_port, clear the cycle counter.
  - On an accepted command: register addr, wdata, size and dir, then go to ACCESS.
- ACCESS (exactly one cycle):
  - S_oe_ram[0] = !write, S_we_ram[0] = write.
  - Addr, wdata and size are driven from the registers.
  - Go to WAIT.
- WAIT:
  - All S_* outputs are 0.
  - Timeout counter increments each cycle.
  - If Sout_DataRdy[0] = 1: capture Sout_Rdata_ram[DATA_W-1:0] into rsp_rdata (forced to 0 for writes), set rsp_error = 0, go to RESP.
  - If the counter reaches TIMEOUT with no DataRdy: rsp_rdata = 0, rsp_error = 1, go to RESP.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_error are held stable.
  - On rsp_ready: go to IDLE.
  - DataRdy arriving in RESP or IDLE is ignored.
- RUN:
  - run_busy = 1 and cmd_ready = 0; the accelerator owns its memory.
  - Counter increments every cycle and saturates at 2^CNT_W-1.
  - On done_port = 1: run_cycles = counter+1 (the start cycle counts as cycle 1), run_done pulses for one cycle, go to IDLE.
  - run_req during RUN is ignored.
- Asserting reset in any state returns to IDLE with all outputs at reset values. An in-flight response is lost.

## Timing
- Reset values: every output 0, including run_cycles, S_* and start_port. cmd_ready becomes 1 on the first cycle after reset is released.
- All outputs are registered except cmd_ready, which is a decode of state and run_req.
- Command accepted at edge N:
  - S_oe/we high in cycle N+1 only.
  - DataRdy sampled from edge N+2 onward.
  - rsp_valid rises the cycle after DataRdy is sampled.
  - Minimum accept-to-rsp_valid latency is 3 cycles.
  - rsp_ready in the first rsp_valid cycle makes cmd_ready 1 on the next cycle.
- Timeout fires after exactly TIMEOUT WAIT cycles.
- run_req sampled at edge N: start_port high for cycle N+1 only. If done_port is sampled high at edge N+1+k, then run_cycles = k+1, run_done is high in cycle N+2+k, and run_busy falls in the same cycle.

## Test plan
- Reset mid-WAIT: hold reset = 0 for 2 cycles during WAIT → all outputs 0, state IDLE, cmd_ready = 1 after release.
- Write then read: write addr 0x05, data 0xA5, size 8 with DataRdy one cycle after oe/we; read 0x05 with the responder returning 0xA5 → rsp_rdata = 0xA5, rsp_error = 0. Check S_addr_ram = 0x0005 and S_data_ram_size = 0x08.
- Timeout: read with DataRdy never asserted and TIMEOUT = 64 → rsp_valid = 1, rsp_error = 1, rsp_rdata = 0 exactly 64 cycles after ACCESS.
- Run latency: run_req with done_port asserted 10 cycles after start_port → run_cycles = 11 and a single run_done pulse. done_port asserted in the start_port cycle → run_cycles = 1.
- Priority and busy: run_req and cmd_valid in the same cycle → run starts, cmd_ready stays 0 until run_done, and the command is accepted the cycle after.
- Backpressure: hold rsp_ready = 0 for 5 cycles → rsp_valid and rsp_rdata stay stable, and no new S_* access is issued.

Source files
------------

// File: rtl/main_slave_port_master.sv
// main_slave_port_master
// Bus master for the slave memory port of a Bambu-generated `main` accelerator.
// Issues single-beat reads/writes on lane 0 of the two-lane slave port, waits
// for DataRdy with a timeout, and runs the start/done handshake while counting
// the accelerator's run latency. Lane 1 of every S_* output is tied to zero.

module main_slave_port_master #(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 8,
   parameter int SIZE_W  = 4,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic                  clock,
   input  logic                  reset,

   // Memory command channel
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [SIZE_W-1:0]     cmd_size,

   // Memory response channel
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_error,

   // Run control
   input  logic                  run_req,
   output logic                  run_busy,
   output logic                  run_done,
   output logic [CNT_W-1:0]      run_cycles,

   // Accelerator handshake
   output logic                  start_port,
   input  logic                  done_port,

   // Accelerator slave memory port (two lanes, lane 0 used)
   output logic [1:0]            S_oe_ram,
   output logic [1:0]            S_we_ram,
   output logic [2*ADDR_W-1:0]   S_addr_ram,
   output logic [2*DATA_W-1:0]   S_Wdata_ram,
   output logic [2*SIZE_W-1:0]   S_data_ram_size,
   input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
   input  logic [1:0]            Sout_DataRdy
);

   // Wide enough to hold TIMEOUT itself so TIMEOUT = 2^n does not wrap.
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_RESP,
      ST_RUN
   } state_e;

   state_e               state_q, state_d;

   // Transaction bookkeeping
   logic                 dir_q, dir_d;            // 1 = write
   logic [TMO_W-1:0]     tmo_q, tmo_d;            // WAIT cycles elapsed
   logic [CNT_W-1:0]     cnt_q, cnt_d;            // RUN cycles elapsed

   // Registered port outputs
   logic                 oe_q, oe_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [SIZE_W-1:0]    size_q, size_d;

   // Registered response / run outputs
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_error_q, rsp_error_d;
   logic                 run_busy_q, run_busy_d;
   logic                 run_done_q, run_done_d;
   logic [CNT_W-1:0]     run_cycles_q, run_cycles_d;
   logic                 start_q, start_d;

   // Decodes
   logic                 run_fire;
   logic                 cmd_fire;
   logic                 rdy_seen;
   logic                 tmo_hit;
   logic [CNT_W-1:0]     cnt_inc;

   // Lane 1 of the slave port carries nothing this master uses.
   logic                 unused_lane1;
   assign unused_lane1 = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

   // A run request wins over a command in the same cycle, so cmd_ready drops
   // whenever run_req is high; it is also held low while reset is asserted.
   assign cmd_ready = reset && (state_q == ST_IDLE) && !run_req;
   assign run_fire  = (state_q == ST_IDLE) && run_req;
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign rdy_seen  = Sout_DataRdy[0];
   assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));
   // Run counter saturates at all-ones instead of wrapping.
   assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   // State and output registers
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         dir_q        <= 1'b0;
         tmo_q        <= '0;
         cnt_q        <= '0;
         oe_q         <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_error_q  <= 1'b0;
         run_busy_q   <= 1'b0;
         run_done_q   <= 1'b0;
         run_cycles_q <= '0;
         start_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         tmo_q        <= tmo_d;
         cnt_q        <= cnt_d;
         oe_q         <= oe_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         size_q       <= size_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_error_q  <= rsp_error_d;
         run_busy_q   <= run_busy_d;
         run_done_q   <= run_done_d;
         run_cycles_q <= run_cycles_d;
         start_q      <= start_d;
      end
   end

   // Next-state decode
   // NOTE: the default assignment first keeps every path assigned, so no
   // latch is inferred for state_d.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (run_fire) begin
               state_d = ST_RUN;
            end else if (cmd_fire) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: state_d = ST_WAIT;
         ST_WAIT: begin
            if (rdy_seen || tmo_hit) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (done_port) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and counters. The S_* registers
   // default to zero so they are high only in the single ACCESS cycle.
   always_comb begin
      dir_d        = dir_q;
      tmo_d        = tmo_q;
      cnt_d        = cnt_q;
      oe_d         = 1'b0;
      we_d         = 1'b0;
      addr_d       = '0;
      wdata_d      = '0;
      size_d       = '0;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_error_d  = rsp_error_q;
      run_busy_d   = run_busy_q;
      run_done_d   = 1'b0;
      run_cycles_d = run_cycles_q;
      start_d      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (run_fire) begin
               start_d    = 1'b1;
               run_busy_d = 1'b1;
               cnt_d      = '0;
            end else if (cmd_fire) begin
               // Load the port registers now so the access shows in ACCESS.
               dir_d   = cmd_write;
               oe_d    = !cmd_write;
               we_d    = cmd_write;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               size_d  = cmd_size;
            end
         end
         ST_ACCESS: begin
            tmo_d = '0;
         end
         ST_WAIT: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (rdy_seen) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = dir_q ? '0 : Sout_Rdata_ram[DATA_W-1:0];
               rsp_error_d = 1'b0;
            end else if (tmo_hit) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_error_d = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (done_port) begin
               // The start cycle itself counts as cycle 1.
               run_cycles_d = cnt_inc;
               run_done_d   = 1'b1;
               run_busy_d   = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: ;
      endcase
   end

   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_error       = rsp_error_q;
   assign run_busy        = run_busy_q;
   assign run_done        = run_done_q;
   assign run_cycles      = run_cycles_q;
   assign start_port      = start_q;
   assign S_oe_ram        = {1'b0, oe_q};
   assign S_we_ram        = {1'b0, we_q};
   assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
   assign S_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q};
   assign S_data_ram_size = {{SIZE_W{1'b0}}, size_q};

endmodule
